hdmi_timing_gen: RTL and testbench



---
 rtl/hdmi_timing_gen.sv | 229 ++++++++++++++++++++++
 tb/tb_hdmi_timing_gen.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen
// Raster timing and pixel source for the HDMI path. It sits between the
// AXI4-Lite register slave and the TMDS encoder. It produces sync and
// data-enable timing, pixel coordinates and 24-bit RGB from one of four
// patterns. The control inputs are shadowed at frame boundaries, so a
// register write never changes a frame that is already being drawn.
//
// Ports
//   ACLK           pixel clock, rising edge
//   ARESET         asynchronous active-high reset
//   ctrl_enable    run request
//   ctrl_bg_color  background colour {R,G,B}
//   ctrl_pattern   0 solid, 1 colour bars, 2 grey ramp, 3 checker
//   hsync, vsync   sync outputs; the active level is set by SYNC_POL
//   de             active-video enable
//   pixel_x/y      coordinates of the pixel currently on the outputs
//   rgb            pixel colour; forced to 0 outside active video
//   frame_start    one-cycle pulse on pixel (0,0)
//   frame_count    number of completed frames
//   busy           high while the raster engine is running
module hdmi_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        ctrl_enable,
    input  logic [23:0] ctrl_bg_color,
    input  logic [1:0]  ctrl_pattern,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic [23:0] rgb,
    output logic        frame_start,
    output logic [31:0] frame_count,
    output logic        busy
);

    localparam int         H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] BAR_W    = 10'(H_ACTIVE / 8);
    localparam logic       SYNC_ON  = (SYNC_POL != 0);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_enableReg;
    logic [9:0]  r_hCnt;
    logic [9:0]  r_vCnt;
    logic [23:0] r_bgShadow;
    logic [1:0]  r_patShadow;
    logic [31:0] r_frameCount;

    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic [9:0]  r_pixX;
    logic [9:0]  r_pixY;
    logic [23:0] r_rgb;
    logic        r_frameStart;

    logic        w_lineEnd;
    logic        w_frameEnd;
    logic        w_reload;
    logic [2:0]  w_barIdx;
    logic [23:0] w_barColor;
    logic        w_de;
    logic        w_hsync;
    logic        w_vsync;
    logic        w_frameStart;
    logic [9:0]  w_pixX;
    logic [9:0]  w_pixY;
    logic [23:0] w_rgb;

    // The enable request goes through one register stage before the FSM
    // acts on it. This gives a fixed start-up latency: RUN one edge after
    // the sample, and the first pixel on the outputs one edge after that.
    assign w_lineEnd  = (r_hCnt == H_LAST);
    assign w_frameEnd = (r_state == RUN) && w_lineEnd && (r_vCnt == V_LAST);
    assign w_reload   = r_enableReg && ((r_state == IDLE) || w_frameEnd);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_enableReg <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_enableReg <= ctrl_enable;
        end
    end

    // A frame always runs to completion. The enable is only checked in IDLE
    // and on the last pixel of a frame.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (r_enableReg) w_nextState = RUN;
            RUN:     if (w_frameEnd && !r_enableReg) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_hCnt       <= 10'd0;
            r_vCnt       <= 10'd0;
            r_frameCount <= 32'd0;
            r_bgShadow   <= 24'd0;
            r_patShadow  <= 2'd0;
        end else begin
            if (r_state == RUN) begin
                if (w_lineEnd) begin
                    r_hCnt <= 10'd0;
                    r_vCnt <= (r_vCnt == V_LAST) ? 10'd0 : r_vCnt + 10'd1;
                end else begin
                    r_hCnt <= r_hCnt + 10'd1;
                end
            end else begin
                r_hCnt <= 10'd0;
                r_vCnt <= 10'd0;
            end
            if (w_frameEnd) begin
                r_frameCount <= r_frameCount + 32'd1;
            end
            if (w_reload) begin
                r_bgShadow  <= ctrl_bg_color;
                r_patShadow <= ctrl_pattern;
            end
        end
    end

    // Bar order white, yellow, cyan, green, magenta, red, blue, black.
    // Beyond the active width the index wraps, but rgb is gated by de there.
    assign w_barIdx = 3'(r_hCnt / BAR_W);

    always_comb begin
        w_barColor = 24'h000000;
        case (w_barIdx)
            3'd0:    w_barColor = 24'hFFFFFF;
            3'd1:    w_barColor = 24'hFFFF00;
            3'd2:    w_barColor = 24'h00FFFF;
            3'd3:    w_barColor = 24'h00FF00;
            3'd4:    w_barColor = 24'hFF00FF;
            3'd5:    w_barColor = 24'hFF0000;
            3'd6:    w_barColor = 24'h0000FF;
            default: w_barColor = 24'h000000;
        endcase
    end

    always_comb begin
        w_de         = 1'b0;
        w_hsync      = ~SYNC_ON;
        w_vsync      = ~SYNC_ON;
        w_frameStart = 1'b0;
        w_pixX       = 10'd0;
        w_pixY       = 10'd0;
        w_rgb        = 24'h000000;
        if (r_state == RUN) begin
            w_pixX       = r_hCnt;
            w_pixY       = r_vCnt;
            w_de         = (r_hCnt < H_ACT) && (r_vCnt < V_ACT);
            w_frameStart = (r_hCnt == 10'd0) && (r_vCnt == 10'd0);
            if ((r_hCnt >= HS_START) && (r_hCnt <= HS_END)) w_hsync = SYNC_ON;
            if ((r_vCnt >= VS_START) && (r_vCnt <= VS_END)) w_vsync = SYNC_ON;
            if (w_de) begin
                case (r_patShadow)
                    2'd0:    w_rgb = r_bgShadow;
                    2'd1:    w_rgb = w_barColor;
                    2'd2:    w_rgb = {r_hCnt[9:2], r_hCnt[9:2], r_hCnt[9:2]};
                    default: w_rgb = (r_hCnt[5] ^ r_vCnt[5]) ? r_bgShadow : 24'h000000;
                endcase
            end
        end
    end

    // The output stage sits one cycle behind the counters. All video
    // outputs come from the same stage, so they stay mutually aligned.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_hsync      <= ~SYNC_ON;
            r_vsync      <= ~SYNC_ON;
            r_de         <= 1'b0;
            r_pixX       <= 10'd0;
            r_pixY       <= 10'd0;
            r_rgb        <= 24'h000000;
            r_frameStart <= 1'b0;
        end else begin
            r_hsync      <= w_hsync;
            r_vsync      <= w_vsync;
            r_de         <= w_de;
            r_pixX       <= w_pixX;
            r_pixY       <= w_pixY;
            r_rgb        <= w_rgb;
            r_frameStart <= w_frameStart;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign pixel_x     = r_pixX;
    assign pixel_y     = r_pixY;
    assign rgb         = r_rgb;
    assign frame_start = r_frameStart;
    assign frame_count = r_frameCount;
    assign busy        = (r_state == RUN);

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Testbench for hdmi_timing_gen. It uses a reduced raster so that several
// frames fit in a short run. A cycle-level reference model pushes the
// expected outputs for each edge into a queue, and the checker pops them
// and compares them against the DUT. Directed checks cover latency,
// shadowing, the patterns, disable and mid-frame reset.
module tb_hdmi_timing_gen;

    localparam int HA    = 64;
    localparam int HFP   = 4;
    localparam int HS    = 8;
    localparam int HBP   = 4;
    localparam int VA    = 40;
    localparam int VFP   = 2;
    localparam int VS    = 2;
    localparam int VBP   = 3;
    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int BAR   = HA / 8;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        ctrl_enable;
    logic [23:0] ctrl_bg_color;
    logic [1:0]  ctrl_pattern;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [23:0] rgb;
    logic        frame_start;
    logic [31:0] frame_count;
    logic        busy;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [9:0]  px;
        logic [9:0]  py;
        logic [23:0] rgb;
        logic        fs;
        logic [31:0] fc;
        logic        busy;
    } outs_t;

    outs_t dutOuts;
    outs_t expQ[$];

    int checks;
    int failures;
    int cycleNo;
    int lastFs;
    int lineDe;
    int fsCount;
    int edges;

    // Reference model state
    bit          mRun;
    int          mH;
    int          mV;
    bit          mEnReg;
    logic [23:0] mBg;
    logic [1:0]  mPat;
    logic [31:0] mCount;

    hdmi_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(0)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .ctrl_enable  (ctrl_enable),
        .ctrl_bg_color(ctrl_bg_color),
        .ctrl_pattern (ctrl_pattern),
        .hsync        (hsync),
        .vsync        (vsync),
        .de           (de),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .rgb          (rgb),
        .frame_start  (frame_start),
        .frame_count  (frame_count),
        .busy         (busy)
    );

    always #5 ACLK = ~ACLK;

    assign dutOuts = {hsync, vsync, de, pixel_x, pixel_y, rgb, frame_start, frame_count, busy};

    task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cycleNo, observed, expected);
        end
    endtask

    function automatic outs_t resetValue();
        outs_t r;
        r = '0;
        r.hs = 1'b1;
        r.vs = 1'b1;
        return r;
    endfunction

    function automatic logic [23:0] modelPixel(input int x, input int y, input logic [1:0] pat, input logic [23:0] bg);
        logic [9:0] xv;
        xv = 10'(x);
        case (pat)
            2'd0: return bg;
            2'd1: begin
                case (x / BAR)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2'd2: return {xv[9:2], xv[9:2], xv[9:2]};
            default: return (((x / 32) % 2) != ((y / 32) % 2)) ? bg : 24'h000000;
        endcase
    endfunction

    task automatic modelReset();
        mRun   = 1'b0;
        mH     = 0;
        mV     = 0;
        mEnReg = 1'b0;
        mBg    = '0;
        mPat   = '0;
        mCount = '0;
        expQ.delete();
    endtask

    // Returns the outputs expected just after the coming edge, then advances the model by one edge.
    task automatic modelStep(output outs_t e);
        bit frameEnd;
        bit nextRun;
        frameEnd = mRun && (mH == HT - 1) && (mV == VT - 1);
        e = resetValue();
        if (mRun) begin
            e.px  = 10'(mH);
            e.py  = 10'(mV);
            e.de  = (mH < HA) && (mV < VA);
            e.hs  = !((mH >= HA + HFP) && (mH < HA + HFP + HS));
            e.vs  = !((mV >= VA + VFP) && (mV < VA + VFP + VS));
            e.rgb = e.de ? modelPixel(mH, mV, mPat, mBg) : 24'h000000;
            e.fs  = (mH == 0) && (mV == 0);
        end
        nextRun = mRun ? !(frameEnd && !mEnReg) : mEnReg;
        if (frameEnd) mCount = mCount + 32'd1;
        e.fc   = mCount;
        e.busy = nextRun;
        if (mEnReg && (!mRun || frameEnd)) begin
            mBg  = ctrl_bg_color;
            mPat = ctrl_pattern;
        end
        if (mRun) begin
            mH++;
            if (mH == HT) begin
                mH = 0;
                mV++;
                if (mV == VT) mV = 0;
            end
        end else begin
            mH = 0;
            mV = 0;
        end
        mRun   = nextRun;
        mEnReg = ctrl_enable;
    endtask

    task automatic observe();
        if (de) lineDe++;
        if (pixel_x == 10'(HT - 1)) begin
            checkOutput("lineDe", 96'(lineDe), 96'((pixel_y < 10'(VA)) ? HA : 0));
            lineDe = 0;
        end
        if (!busy) lastFs = -1;
        if (frame_start) begin
            fsCount++;
            if (lastFs >= 0) checkOutput("framePeriod", 96'(cycleNo - lastFs), 96'(FRAME));
            lastFs = cycleNo;
        end
    endtask

    // One clock edge: push the model's expectation, advance, then pop and compare.
    task automatic applyStimulus();
        outs_t e;
        outs_t got;
        if (ARESET) begin
            @(posedge ACLK);
            #1;
            cycleNo++;
            checkOutput("resetHold", dutOuts, resetValue());
        end else begin
            modelStep(e);
            expQ.push_back(e);
            @(posedge ACLK);
            #1;
            cycleNo++;
            got = expQ.pop_front();
            checkOutput("cycle", dutOuts, got);
            observe();
        end
    endtask

    task automatic runUntilFs(input int limit, output int n);
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!frame_start && n < limit);
        checkOutput("fsReached", 96'(frame_start), 96'd1);
    endtask

    task automatic runUntilXY(input int x, input int y);
        int n;
        n = 0;
        while (!(pixel_x == 10'(x) && pixel_y == 10'(y)) && n < FRAME + 100) begin
            applyStimulus();
            n++;
        end
        checkOutput("xyReached", 96'(pixel_x == 10'(x) && pixel_y == 10'(y)), 96'd1);
    endtask

    task automatic doMidReset();
        ARESET = 1'b1;
        #1;
        checkOutput("midReset", dutOuts, resetValue());
        modelReset();
        lineDe = 0;
        lastFs = -1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        cycleNo       = 0;
        lastFs        = -1;
        lineDe        = 0;
        fsCount       = 0;
        ARESET        = 1'b1;
        ctrl_enable   = 1'b1;
        ctrl_bg_color = 24'h123456;
        ctrl_pattern  = 2'd0;
        modelReset();

        // Hold reset with enable high, then release and measure start-up latency
        for (int i = 0; i < 3; i++) applyStimulus();
        ARESET = 1'b0;
        runUntilFs(10, edges);
        checkOutput("startLatency", 96'(edges), 96'd3);
        checkOutput("firstPixel", {pixel_x, pixel_y, de, busy}, {10'd0, 10'd0, 1'b1, 1'b1});

        // Background written mid-frame only shows up from the next frame
        runUntilXY(0, 20);
        ctrl_bg_color = 24'hABCDEF;
        runUntilXY(5, 30);
        checkOutput("shadowHold", 96'(rgb), 96'h123456);
        runUntilFs(FRAME + 10, edges);
        runUntilXY(5, 5);
        checkOutput("shadowNew", 96'(rgb), 96'hABCDEF);

        // Colour bars on line 0
        ctrl_pattern = 2'd1;
        runUntilFs(FRAME + 10, edges);
        runUntilXY(BAR - 1, 0);
        checkOutput("barWhite", 96'(rgb), 96'hFFFFFF);
        runUntilXY(BAR, 0);
        checkOutput("barYellow", 96'(rgb), 96'hFFFF00);
        runUntilXY(HA - 1, 0);
        checkOutput("barBlack", {de, rgb}, {1'b1, 24'h000000});
        runUntilXY(HA, 0);
        checkOutput("barBlank", {de, rgb}, {1'b0, 24'h000000});

        // Grey ramp and checker
        ctrl_pattern = 2'd2;
        runUntilFs(FRAME + 10, edges);
        runUntilXY(21, 3);
        checkOutput("greyRamp", 96'(rgb), 96'h050505);
        ctrl_pattern = 2'd3;
        runUntilFs(FRAME + 10, edges);
        runUntilXY(33, 0);
        checkOutput("checkerOn", 96'(rgb), 96'hABCDEF);
        runUntilXY(1, 32);
        checkOutput("checkerOn2", 96'(rgb), 96'hABCDEF);
        runUntilXY(33, 32);
        checkOutput("checkerOff", 96'(rgb), 96'h000000);

        // Disable mid-frame: the frame completes, then the engine stays idle
        ctrl_enable = 1'b0;
        runUntilXY(HT - 1, VT - 1);
        checkOutput("frameDone", {frame_count, busy}, {32'd5, 1'b0});
        fsCount = 0;
        for (int i = 0; i < 100; i++) applyStimulus();
        checkOutput("noRestart", 96'(fsCount), 96'd0);
        checkOutput("idleOutputs", {hsync, vsync, de, pixel_x, pixel_y, rgb, frame_count, busy},
                    {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 24'h0, 32'd5, 1'b0});

        // Restart, then reset in the middle of the frame
        ctrl_enable = 1'b1;
        runUntilFs(10, edges);
        checkOutput("restartLatency", 96'(edges), 96'd3);
        runUntilXY(0, 30);
        doMidReset();
        applyStimulus();
        applyStimulus();
        ARESET = 1'b0;
        runUntilFs(10, edges);
        checkOutput("resetRestart", {pixel_x, pixel_y, de, frame_count}, {10'd0, 10'd0, 1'b1, 32'd0});
        runUntilXY(0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
